// File: rtl/bch_bit_packer_if.sv
// bch_bit_packer_if: byte-in / bit-out handshake bundle between byte source, packer and BCH encoder
interface bch_bit_packer_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] byte_data;
  logic byte_valid;
  logic byte_ready;
  logic flush;
  logic bit_valid;
  logic bit_ready;
  logic bit_data;
  logic bit_last;
  logic busy;
  modport master (output byte_data, byte_valid, flush, bit_ready,
                  input byte_ready, bit_valid, bit_data, bit_last, busy);
  modport slave (input byte_data, byte_valid, flush, bit_ready,
                 output byte_ready, bit_valid, bit_data, bit_last, busy);
endinterface

// File: rtl/bch_bit_packer.sv
// bch_bit_packer: MSB-first byte serializer into BLOCK_BITS message blocks with zero-pad flush; BCH_BIT_PACKER_SCRAMBLE_EN adds an x^7+x^6+1 output scrambler
module bch_bit_packer #(
  parameter int BLOCK_BITS = 51,
  parameter int DATA_W = 8,
  parameter int BUF_BITS = 16
) (
  input logic clk,
  input logic rst,
  bch_bit_packer_if.slave bus
);
  localparam int CW = $clog2(BUF_BITS + 1);
  localparam int PW = $clog2(BLOCK_BITS);
  logic [BUF_BITS-1:0] sreg, sh, sreg_n;
  logic [CW-1:0] cnt, c1, cnt_n;
  logic [PW-1:0] bitpos, bitpos_n;
  logic pad_pend, pad_n, bt, xt, last, raw, drain;
  always_comb begin
    bus.byte_ready = !rst && !pad_pend && (cnt <= CW'(BUF_BITS - DATA_W));
    bus.bit_valid = (cnt != '0) || pad_pend;
    raw = (cnt != '0) && sreg[BUF_BITS-1];
    last = bitpos == PW'(BLOCK_BITS - 1);
    bus.bit_last = bus.bit_valid && last;
    bus.busy = (cnt != '0) || pad_pend || (bitpos != '0);
    bt = bus.bit_valid && bus.bit_ready;
    xt = bus.byte_valid && bus.byte_ready;
    drain = bt && (cnt != '0);
    sh = drain ? sreg << 1 : sreg;
    c1 = drain ? cnt - 1'b1 : cnt;
    sreg_n = xt ? sh | ({bus.byte_data, {(BUF_BITS-DATA_W){1'b0}}} >> c1) : sh;
    cnt_n = xt ? c1 + CW'(DATA_W) : c1;
    bitpos_n = bt ? (last ? '0 : bitpos + 1'b1) : bitpos;
    pad_n = pad_pend ? !(bt && last) : bus.flush && ((bitpos_n != '0) || (cnt_n != '0));
  end
  always_ff @(posedge clk)
    if (rst) begin
      sreg <= '0;
      cnt <= '0;
      bitpos <= '0;
      pad_pend <= 1'b0;
    end else begin
      sreg <= sreg_n;
      cnt <= cnt_n;
      bitpos <= bitpos_n;
      pad_pend <= pad_n;
    end
`ifdef BCH_BIT_PACKER_SCRAMBLE_EN
  logic [6:0] lfsr;
  logic s;
  assign s = lfsr[6] ^ lfsr[5];
  assign bus.bit_data = raw ^ s;
  always_ff @(posedge clk)
    if (rst || (bt && last)) lfsr <= 7'h7F;
    else if (bt) lfsr <= {lfsr[5:0], s};
`else
  assign bus.bit_data = raw;
`endif
endmodule

// File: tb/tb_bch_bit_packer.sv
// tb_bch_bit_packer: directed self-checking bench for bch_bit_packer
module tb_bch_bit_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int pass_cnt = 0;
  int tot = 0;
  bit q[$];
  bit lq[$];
  bch_bit_packer_if #(.DATA_W(8)) bi();
  bch_bit_packer dut (.clk(clk), .rst(rst), .bus(bi.slave));
  always #5 clk = ~clk;
  always @(negedge clk)
    if (!rst && bi.bit_valid && bi.bit_ready) begin
      q.push_back(bi.bit_data);
      lq.push_back(bi.bit_last);
    end
  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic do_reset();
    rst = 1'b1;
    bi.byte_valid = 1'b0;
    bi.byte_data = '0;
    bi.flush = 1'b0;
    bi.bit_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    lq.delete();
  endtask
  task automatic send(input logic [7:0] w);
    int t = 0;
    bi.byte_data = w;
    bi.byte_valid = 1'b1;
    @(negedge clk);
    while (!bi.byte_ready && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!bi.byte_ready) begin
      tot++;
      $display("FAIL send_timeout byte_ready got 0 want 1 (word %h)", w);
    end
    @(posedge clk);
    #1;
    bi.byte_valid = 1'b0;
  endtask
  task automatic wait_bits(input int n);
    int t = 0;
    while (q.size() < n && t < 2000) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (q.size() < n) begin
      tot++;
      $display("FAIL wait_bits got %0d bits want %0d", q.size(), n);
    end
  endtask
  task automatic pulse_flush();
    bi.flush = 1'b1;
    @(posedge clk);
    #1;
    bi.flush = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bi.byte_valid = 1'b0;
    bi.flush = 1'b0;
    bi.bit_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tot++; if (bi.byte_ready !== 1'b0) $display("FAIL rst_byte_ready got %b want 0", bi.byte_ready); else pass_cnt++;
    tot++; if (bi.bit_valid !== 1'b0) $display("FAIL rst_bit_valid got %b want 0", bi.bit_valid); else pass_cnt++;
    tot++; if (bi.bit_data !== 1'b0) $display("FAIL rst_bit_data got %b want 0", bi.bit_data); else pass_cnt++;
    tot++; if (bi.bit_last !== 1'b0) $display("FAIL rst_bit_last got %b want 0", bi.bit_last); else pass_cnt++;
    tot++; if (bi.busy !== 1'b0) $display("FAIL rst_busy got %b want 0", bi.busy); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    tot++; if (bi.byte_ready !== 1'b1) $display("FAIL rst_release_byte_ready got %b want 1", bi.byte_ready); else pass_cnt++;
  endtask
  task automatic test_stream();
    logic [7:0] w [7] = '{8'hFF, 8'h00, 8'hAA, 8'h55, 8'hF0, 8'h0F, 8'hC3};
    int bad = 0;
    int lbad = 0;
    do_reset();
    bi.bit_ready = 1'b1;
    for (int i = 0; i < 7; i++) send(w[i]);
    wait_bits(56);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 56; i++) begin
      if (i >= q.size() || q[i] != w[i/8][7-(i%8)]) bad++;
      if (i >= lq.size() || lq[i] != (i == 50)) lbad++;
    end
    tot++; if (bad != 0) $display("FAIL stream_bits mismatched %0d of 56 want 0", bad); else pass_cnt++;
    tot++; if (lbad != 0) $display("FAIL stream_last misplaced %0d flags want 0 (last only at bit 51)", lbad); else pass_cnt++;
    tot++; if (q.size() != 56) $display("FAIL stream_count got %0d bits want 56", q.size()); else pass_cnt++;
    tot++; if (bi.busy !== 1'b1) $display("FAIL stream_busy got %b want 1", bi.busy); else pass_cnt++;
    tot++; if (bi.bit_valid !== 1'b0) $display("FAIL stream_empty_valid got %b want 0", bi.bit_valid); else pass_cnt++;
  endtask
  task automatic test_backpressure();
    logic [7:0] w [3] = '{8'hC3, 8'h81, 8'h7E};
    int bad = 0;
    bit stable = 1'b1;
    do_reset();
    bi.bit_ready = 1'b0;
    bi.byte_data = w[0];
    bi.byte_valid = 1'b1;
    @(posedge clk);
    #1;
    bi.byte_data = w[1];
    @(posedge clk);
    #1;
    bi.byte_data = w[2];
    tot++; if (bi.byte_ready !== 1'b0) $display("FAIL bp_full_byte_ready got %b want 0", bi.byte_ready); else pass_cnt++;
    tot++; if (bi.bit_valid !== 1'b1) $display("FAIL bp_bit_valid got %b want 1", bi.bit_valid); else pass_cnt++;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bi.bit_data !== 1'b1 || bi.byte_ready !== 1'b0 || bi.bit_valid !== 1'b1) stable = 1'b0;
    end
    tot++; if (!stable) $display("FAIL bp_hold outputs changed got unstable want stable"); else pass_cnt++;
    tot++; if (q.size() != 0) $display("FAIL bp_no_transfer got %0d bits want 0", q.size()); else pass_cnt++;
    bi.bit_ready = 1'b1;
    send(w[2]);
    wait_bits(24);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 24; i++) if (i >= q.size() || q[i] != w[i/8][7-(i%8)]) bad++;
    tot++; if (bad != 0) $display("FAIL bp_order mismatched %0d of 24 want 0", bad); else pass_cnt++;
    tot++; if (q.size() != 24) $display("FAIL bp_count got %0d bits want 24", q.size()); else pass_cnt++;
  endtask
  task automatic test_flush();
    logic [7:0] w = 8'hA5;
    int bad = 0;
    int lbad = 0;
    do_reset();
    bi.bit_ready = 1'b1;
    send(w);
    pulse_flush();
    tot++; if (bi.byte_ready !== 1'b0) $display("FAIL flush_byte_ready got %b want 0", bi.byte_ready); else pass_cnt++;
    tot++; if (bi.busy !== 1'b1) $display("FAIL flush_busy_pad got %b want 1", bi.busy); else pass_cnt++;
    pulse_flush();
    wait_bits(51);
    tot++; if (bi.busy !== 1'b0) $display("FAIL flush_busy_done got %b want 0", bi.busy); else pass_cnt++;
    tot++; if (bi.byte_ready !== 1'b1) $display("FAIL flush_ready_done got %b want 1", bi.byte_ready); else pass_cnt++;
    for (int i = 0; i < 51; i++) begin
      if (i >= q.size() || q[i] != (i < 8 ? w[7-i] : 1'b0)) bad++;
      if (i >= lq.size() || lq[i] != (i == 50)) lbad++;
    end
    tot++; if (bad != 0) $display("FAIL flush_bits mismatched %0d of 51 want 0", bad); else pass_cnt++;
    tot++; if (lbad != 0) $display("FAIL flush_last misplaced %0d flags want 0", lbad); else pass_cnt++;
    pulse_flush();
    repeat (2) @(posedge clk);
    #1;
    tot++; if (bi.busy !== 1'b0 || bi.bit_valid !== 1'b0) $display("FAIL flush_idle busy=%b valid=%b want 0 0", bi.busy, bi.bit_valid); else pass_cnt++;
    tot++; if (q.size() != 51) $display("FAIL flush_count got %0d bits want 51", q.size()); else pass_cnt++;
  endtask
  task automatic test_simultaneous();
    logic [7:0] w [2] = '{8'h96, 8'h3F};
    int bad = 0;
    do_reset();
    bi.bit_ready = 1'b0;
    send(w[0]);
    bi.bit_ready = 1'b1;
    bi.byte_data = w[1];
    bi.byte_valid = 1'b1;
    @(posedge clk);
    #1;
    bi.byte_valid = 1'b0;
    tot++; if (dut.cnt !== 5'd15) $display("FAIL sim_cnt got %0d want 15", dut.cnt); else pass_cnt++;
    tot++; if (bi.byte_ready !== 1'b0) $display("FAIL sim_byte_ready got %b want 0", bi.byte_ready); else pass_cnt++;
    wait_bits(16);
    for (int i = 0; i < 16; i++) if (i >= q.size() || q[i] != w[i/8][7-(i%8)]) bad++;
    tot++; if (bad != 0) $display("FAIL sim_order mismatched %0d of 16 want 0", bad); else pass_cnt++;
  endtask
  task automatic test_mid_reset();
    int lbad = 0;
    do_reset();
    bi.bit_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(8'hFF);
    wait_bits(20);
    bi.bit_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    tot++; if (bi.byte_ready !== 1'b0 || bi.bit_valid !== 1'b0 || bi.bit_data !== 1'b0 || bi.bit_last !== 1'b0 || bi.busy !== 1'b0)
      $display("FAIL mid_rst outputs ready=%b valid=%b data=%b last=%b busy=%b want 0 0 0 0 0", bi.byte_ready, bi.bit_valid, bi.bit_data, bi.bit_last, bi.busy);
    else pass_cnt++;
    rst = 1'b0;
    q.delete();
    lq.delete();
    #1;
    tot++; if (bi.byte_ready !== 1'b1) $display("FAIL mid_rst_release got %b want 1", bi.byte_ready); else pass_cnt++;
    bi.bit_ready = 1'b1;
    for (int i = 0; i < 7; i++) send(8'h5A);
    wait_bits(51);
    for (int i = 0; i < 51; i++) if (i >= lq.size() || lq[i] != (i == 50)) lbad++;
    tot++; if (lbad != 0) $display("FAIL mid_rst_block misplaced %0d last flags want 0", lbad); else pass_cnt++;
  endtask
  task automatic test_scramble();
`ifdef BCH_BIT_PACKER_SCRAMBLE_EN
    logic [7:0] v;
    do_reset();
    bi.bit_ready = 1'b1;
    send(8'h00);
    pulse_flush();
    send(8'h00);
    pulse_flush();
    wait_bits(102);
    for (int i = 0; i < 8; i++) v[7-i] = q[i];
    tot++; if (v !== 8'h02) $display("FAIL scr_block1 got %h want 02", v); else pass_cnt++;
    for (int i = 0; i < 8; i++) v[7-i] = q[51+i];
    tot++; if (v !== 8'h02) $display("FAIL scr_block2 got %h want 02", v); else pass_cnt++;
`endif
  endtask
  initial begin
    bi.byte_data = '0;
    bi.byte_valid = 1'b0;
    bi.flush = 1'b0;
    bi.bit_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_simultaneous();
    test_mid_reset();
    test_scramble();
    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end
endmodule
